regfile_multiport: RTL

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_multiport_pkg.sv | 29 ++
 rtl/regfile_multiport_defines.sv | 7 +
 rtl/regfile_scoreboard.sv | 38 +++
 rtl/regfile_multiport.sv | 107 ++++++++++
 4 files changed

// File: rtl/regfile_multiport_pkg.sv
// Shared types and constants for the multiport register file and its scoreboard.
`ifndef REGFILE_WORD_SIZE
`define REGFILE_WORD_SIZE 32
`endif
`ifndef REGFILE_NUM_REGS
`define REGFILE_NUM_REGS 32
`endif

package regfile_multiport_pkg;
   localparam int ZERO_REG       = 0;
   localparam int PKG_WORD_SIZE  = `REGFILE_WORD_SIZE;
   localparam int PKG_ADDR_WIDTH = $clog2(`REGFILE_NUM_REGS);

   typedef struct packed {
      logic                      en;
      logic [PKG_ADDR_WIDTH-1:0] addr;
   } rd_req_t;

   typedef struct packed {
      logic                      en;
      logic [PKG_ADDR_WIDTH-1:0] addr;
      logic [PKG_WORD_SIZE-1:0]  data;
   } wr_req_t;

   // Register 0 is hardwired: it never stores data nor becomes pending.
   function automatic logic is_writable(input int addr);
      return addr != ZERO_REG;
   endfunction
endpackage

// File: rtl/regfile_multiport_defines.sv
// Shared build-wide defaults for the multiport register file.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
`ifndef REGFILE_MULTIPORT_DEFINES
`define REGFILE_MULTIPORT_DEFINES
`define REGFILE_WORD_SIZE 32
`define REGFILE_NUM_REGS  32
`endif

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: reserve sets a bit, register writes clear it, set wins.
module regfile_scoreboard
   import regfile_multiport_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [ADDR_WIDTH-1:0] set_addr,
   input  logic [NUM_REGS-1:0]   clr_mask,
`ifdef REGFILE_BYPASS_EN
   output logic [NUM_REGS-1:0]   pend_next,
`endif
   output logic [NUM_REGS-1:0]   pend
);

   logic [NUM_REGS-1:0] pend_d;
   logic [NUM_REGS-1:0] pend_q;

   always_comb begin
      pend_d = pend_q & ~clr_mask;
      if (set_en && is_writable(int'(set_addr))) pend_d[set_addr] = 1'b1;
      pend_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end

   assign pend = pend_q;
`ifdef REGFILE_BYPASS_EN
   assign pend_next = pend_d;
`endif

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with registered reads and a pending-bit scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes and pending updates to reads.
`ifndef REGFILE_WORD_SIZE
`define REGFILE_WORD_SIZE 32
`endif
`ifndef REGFILE_NUM_REGS
`define REGFILE_NUM_REGS 32
`endif

module regfile_multiport
   import regfile_multiport_pkg::*;
#(
   parameter int WORD_SIZE           = `REGFILE_WORD_SIZE,
   parameter int NUMBER_OF_REGISTERS = `REGFILE_NUM_REGS,
   parameter int NUM_RD              = 3,
   parameter int NUM_WR              = 2,
   parameter int ADDR_WIDTH          = $clog2(NUMBER_OF_REGISTERS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_RD-1:0]            rd_en,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*WORD_SIZE-1:0]  rd_data,
   output logic [NUM_RD-1:0]            rd_pend,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_WR*WORD_SIZE-1:0]  wr_data,
   input  logic                         rsv_en,
   input  logic [ADDR_WIDTH-1:0]        rsv_addr
);

   logic [WORD_SIZE-1:0]           regs_q [NUMBER_OF_REGISTERS];
   logic [WORD_SIZE-1:0]           regs_d [NUMBER_OF_REGISTERS];
   logic [NUMBER_OF_REGISTERS-1:0] clr_mask;
   logic [NUMBER_OF_REGISTERS-1:0] pend;
   logic [NUM_RD*WORD_SIZE-1:0]    rd_data_q, rd_data_d;
   logic [NUM_RD-1:0]              rd_pend_q, rd_pend_d;
`ifdef REGFILE_BYPASS_EN
   logic [NUMBER_OF_REGISTERS-1:0] pend_next;
`endif

   // Ports are applied in ascending order so the higher-index port wins a collision.
   always_comb begin
      logic [ADDR_WIDTH-1:0] wa;
      regs_d   = regs_q;
      clr_mask = '0;
      wa       = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         wa = wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
         if (wr_en[j] && is_writable(int'(wa))) begin
            regs_d[wa]   = wr_data[j*WORD_SIZE +: WORD_SIZE];
            clr_mask[wa] = 1'b1;
         end
      end
   end

   regfile_scoreboard #(
      .NUM_REGS   (NUMBER_OF_REGISTERS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en    (rsv_en),
      .set_addr  (rsv_addr),
      .clr_mask  (clr_mask),
`ifdef REGFILE_BYPASS_EN
      .pend_next (pend_next),
`endif
      .pend      (pend)
   );

   // Idle ports hold their last result.
   always_comb begin
      logic [ADDR_WIDTH-1:0] ra;
      rd_data_d = rd_data_q;
      rd_pend_d = rd_pend_q;
      ra        = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         if (rd_en[i]) begin
`ifdef REGFILE_BYPASS_EN
            rd_data_d[i*WORD_SIZE +: WORD_SIZE] = regs_d[ra];
            rd_pend_d[i]                        = pend_next[ra];
`else
            rd_data_d[i*WORD_SIZE +: WORD_SIZE] = regs_q[ra];
            rd_pend_d[i]                        = pend[ra];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q    <= '{default: '0};
         rd_data_q <= '0;
         rd_pend_q <= '0;
      end else begin
         regs_q    <= regs_d;
         rd_data_q <= rd_data_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   assign rd_data = rd_data_q;
   assign rd_pend = rd_pend_q;

endmodule
